// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and constants for the keypad entry controller.
//   key_state_t        - press-tracking FSM states
//   KEY_W              - key code width from the scanner
//   DEF_*_CYCLES       - default debounce / release sample counts
package keypad_pkg;

  localparam int KEY_W               = 4;
  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_RELEASE_CYCLES  = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } key_state_t;

endpackage

// File: rtl/keypad_event_fifo.sv
// keypad_event_fifo: small circular queue of accepted key codes.
//   clock, reset  - rising-edge clock, async active-low reset
//   push          - request to enqueue push_data (taken if not full, or if popping)
//   pop           - dequeue the head entry (ignored when empty)
//   head          - head entry, forced to zero while empty
//   empty, full   - occupancy flags decoded from the registered count
//   count         - number of queued entries
module keypad_event_fifo
  import keypad_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        push,
  input  logic [KEY_W-1:0]            push_data,
  input  logic                        pop,
  output logic [KEY_W-1:0]            head,
  output logic                        empty,
  output logic                        full,
  output logic [$clog2(FIFO_DEPTH):0] count
);

  localparam int                PTR_W    = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0]    FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

  logic [KEY_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop & ~empty;
  // A push into a full queue still fits when the head leaves on the same edge.
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + (PTR_W + 1)'(do_push) - (PTR_W + 1)'(do_pop);
    end
  end

  // Storage carries data only; validity comes from count.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/keypad_entry_controller.sv
// keypad_entry_controller: debounces the keypad scanner's Code/Valid pair,
// emits one event per physical press into a small queue, and pauses the
// scanner while the queue is full.
//   clock, reset         - rising-edge clock, async active-low reset
//   key_code, key_valid  - scanner outputs (already synchronous)
//   scan_en              - 1 = scanner may run, 0 = hold current column
//   out_code, out_valid  - head of the event queue
//   out_ready            - consumer takes the head when out_valid & out_ready
//   fifo_count           - queued entries
//   overflow, clear_ovf  - sticky dropped-press flag and its clear
module keypad_entry_controller
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int RELEASE_CYCLES  = DEF_RELEASE_CYCLES,
  parameter int FIFO_DEPTH      = 4,
  parameter int CNT_W           = 8
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [KEY_W-1:0]            key_code,
  input  logic                        key_valid,
  output logic                        scan_en,
  output logic [KEY_W-1:0]            out_code,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow,
  input  logic                        clear_ovf
);

  localparam logic [CNT_W-1:0] DB_TERM  = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] REL_TERM = CNT_W'(RELEASE_CYCLES);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                              input logic [CNT_W-1:0] term);
    return (v >= term) ? term : v + CNT_W'(1);
  endfunction

  key_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [KEY_W-1:0] cand;
  logic             press_done;
  logic             release_done;
  logic             pop;
  logic             fifo_empty;
  logic             fifo_full;

  // The sample that completes the stable run pushes on the same edge the FSM
  // enters HELD, so the event is visible right after that edge.
  assign press_done   = (state == DEBOUNCE) && key_valid && (key_code == cand) &&
                        (sat_inc(cnt, DB_TERM) == DB_TERM);
  assign release_done = (state == RELEASE) && !key_valid &&
                        (sat_inc(cnt, REL_TERM) == REL_TERM);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      cand  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (key_valid) begin
            state <= DEBOUNCE;
            cand  <= key_code;
            cnt   <= CNT_W'(1);
          end
        end
        DEBOUNCE: begin
          if (!key_valid || key_code != cand) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= sat_inc(cnt, DB_TERM);
            if (press_done) state <= HELD;
          end
        end
        HELD: begin
          // Code changes while held are ignored; only a release re-arms.
          if (!key_valid) begin
            state <= RELEASE;
            cnt   <= CNT_W'(1);
          end
        end
        RELEASE: begin
          if (key_valid) begin
            state <= HELD;
            cnt   <= '0;
          end else if (release_done) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= sat_inc(cnt, REL_TERM);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  keypad_event_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (press_done),
    .push_data(cand),
    .pop      (pop),
    .head     (out_code),
    .empty    (fifo_empty),
    .full     (fifo_full),
    .count    (fifo_count)
  );

  assign out_valid = ~fifo_empty;
  assign pop       = out_valid & out_ready;
  assign scan_en   = ~fifo_full;

  // A press is lost only when full with no pop on the same edge; set beats clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
    end else if (press_done && fifo_full && !pop) begin
      overflow <= 1'b1;
    end else if (clear_ovf) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_keypad_entry_controller.sv
// Bench for keypad_entry_controller: directed scenarios plus randomized
// keystroke traffic, compared every cycle against a behavioural model.
module tb_keypad_entry_controller;

  localparam int DB  = 4;
  localparam int RC  = 4;
  localparam int D   = 4;
  localparam int FCW = $clog2(D) + 1;

  logic           clock = 1'b0;
  logic           reset = 1'b0;
  logic [3:0]     key_code = '0;
  logic           key_valid = 1'b0;
  logic           out_ready = 1'b0;
  logic           clear_ovf = 1'b0;
  logic           scan_en;
  logic           out_valid;
  logic           overflow;
  logic [3:0]     out_code;
  logic [FCW-1:0] fifo_count;

  always #5 clock = ~clock;

  keypad_entry_controller #(
    .DEBOUNCE_CYCLES(DB),
    .RELEASE_CYCLES (RC),
    .FIFO_DEPTH     (D),
    .CNT_W          (8)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .key_code  (key_code),
    .key_valid (key_valid),
    .scan_en   (scan_en),
    .out_code  (out_code),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .fifo_count(fifo_count),
    .overflow  (overflow),
    .clear_ovf (clear_ovf)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Behavioural model: a press is a run of DB equal-code valid samples that
  // starts from idle (a code change breaks the run and that sample is lost);
  // once pressed, RC consecutive invalid samples end the press.
  bit         m_pressed = 0;
  int         m_run     = 0;
  int         m_quiet   = 0;
  logic [3:0] m_code    = '0;
  logic [3:0] m_q[$];
  bit         m_ovf     = 0;
  logic [3:0] obs_pops[$];

  task automatic model_reset();
    m_pressed = 0;
    m_run     = 0;
    m_quiet   = 0;
    m_q.delete();
    m_ovf     = 0;
  endtask

  task automatic model_edge();
    bit emit = 0;
    bit drop = 0;
    bit pop;
    pop = (m_q.size() > 0) && out_ready;
    if (!m_pressed) begin
      if (!key_valid)              m_run = 0;
      else if (m_run == 0)         begin m_run = 1; m_code = key_code; end
      else if (key_code == m_code) m_run++;
      else                         m_run = 0;
      if (m_run == DB) begin
        emit      = 1;
        m_pressed = 1;
        m_run     = 0;
        m_quiet   = 0;
      end
    end else begin
      if (key_valid) m_quiet = 0;
      else           m_quiet++;
      if (m_quiet == RC) begin
        m_pressed = 0;
        m_quiet   = 0;
      end
    end
    if (pop) void'(m_q.pop_front());
    if (emit) begin
      if (m_q.size() < D) m_q.push_back(m_code);
      else                drop = 1;
    end
    if (drop)           m_ovf = 1;
    else if (clear_ovf) m_ovf = 0;
  endtask

  task automatic check_outs();
    int sz = m_q.size();
    check_val("out_valid",  out_valid,  (sz > 0) ? 1 : 0);
    check_val("out_code",   out_code,   (sz > 0) ? m_q[0] : 4'h0);
    check_val("fifo_count", fifo_count, sz);
    check_val("scan_en",    scan_en,    (sz != D) ? 1 : 0);
    check_val("overflow",   overflow,   m_ovf);
  endtask

  // One clock: apply inputs, log the handshake the DUT offers, advance the
  // model on the edge, compare just after it.
  task automatic step(input bit v, input logic [3:0] c);
    key_valid = v;
    key_code  = c;
    #1;
    if (out_valid && out_ready) obs_pops.push_back(out_code);
    @(posedge clock);
    model_edge();
    #1;
    check_outs();
  endtask

  task automatic press(input logic [3:0] c, input int hold, input int rel);
    for (int i = 0; i < hold; i++) step(1'b1, c);
    for (int i = 0; i < rel; i++)  step(1'b0, 4'h0);
  endtask

  // codes holds the expected consumed sequence, first entry in the low nibble.
  task automatic check_seq(input string tag, input int n, input logic [31:0] codes);
    check_val({tag, "_len"}, obs_pops.size(), n);
    for (int i = 0; i < n; i++)
      check_val(tag, (i < obs_pops.size()) ? {28'h0, obs_pops[i]} : 32'hFFFF, codes[4*i +: 4]);
    obs_pops.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int first;
    // Reset state
    #12;
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_out_code",  out_code,  0);
    check_val("rst_count",     fifo_count, 0);
    check_val("rst_scan_en",   scan_en,   1);
    check_val("rst_overflow",  overflow,  0);
    reset = 1'b1;
    model_reset();

    // Clean press with latency check
    out_ready = 1'b1;
    first = -1;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 4'h5);
      if (first < 0 && out_valid) first = i;
    end
    check_val("clean_latency", first, DB - 1);
    for (int i = 0; i < 10; i++) step(1'b0, 4'h0);
    check_val("clean_count0", fifo_count, 0);
    check_seq("clean_seq", 1, 32'h5);

    // Bounce on press, then a release glitch while held
    step(1'b1, 4'hA); step(1'b1, 4'hA); step(1'b0, 4'h0);
    for (int i = 0; i < 7; i++) step(1'b1, 4'hA);
    step(1'b0, 4'h0); step(1'b0, 4'h0); step(1'b1, 4'hA);
    for (int i = 0; i < 3; i++) step(1'b1, 4'hA);
    for (int i = 0; i < 6; i++) step(1'b0, 4'h0);
    check_seq("bounce_seq", 1, 32'hA);

    // Candidate replaced mid-debounce
    step(1'b1, 4'h3); step(1'b1, 4'h3);
    for (int i = 0; i < 8; i++) step(1'b1, 4'h7);
    for (int i = 0; i < 6; i++) step(1'b0, 4'h0);
    check_seq("codechg_seq", 1, 32'h7);

    // Backpressure and overflow
    out_ready = 1'b0;
    for (int k = 1; k <= 4; k++) press(4'(k), 5, 5);
    check_val("bp_scan_en_full", scan_en, 0);
    press(4'h5, 5, 5);
    check_val("bp_overflow", overflow, 1);
    check_val("bp_count_full", fifo_count, D);
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) step(1'b0, 4'h0);
    check_seq("bp_drain_seq", 4, 32'h4321);
    clear_ovf = 1'b1;
    step(1'b0, 4'h0);
    clear_ovf = 1'b0;
    check_val("bp_clear_ovf", overflow, 0);

    // Push and pop on the same edge while full
    out_ready = 1'b0;
    press(4'h8, 5, 5); press(4'h9, 5, 5); press(4'hA, 5, 5); press(4'hB, 5, 5);
    for (int i = 0; i < DB - 1; i++) step(1'b1, 4'hC);
    out_ready = 1'b1;
    step(1'b1, 4'hC);
    check_val("simul_count", fifo_count, D);
    check_val("simul_overflow", overflow, 0);
    step(1'b1, 4'hC);
    for (int i = 0; i < 8; i++) step(1'b0, 4'h0);
    check_seq("simul_seq", 5, 32'hCBA98);

    // Async reset while a key is held with two entries queued
    out_ready = 1'b0;
    press(4'h6, 5, 5);
    for (int i = 0; i < 6; i++) step(1'b1, 4'h7);
    check_val("arst_pre_count", fifo_count, 2);
    #2;
    reset = 1'b0;
    #1;
    check_val("arst_out_valid", out_valid, 0);
    check_val("arst_out_code",  out_code,  0);
    check_val("arst_count",     fifo_count, 0);
    check_val("arst_scan_en",   scan_en,   1);
    check_val("arst_overflow",  overflow,  0);
    model_reset();
    obs_pops.delete();
    #10;
    reset = 1'b1;
    out_ready = 1'b1;
    first = -1;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 4'h7);
      if (first < 0 && out_valid) first = i;
    end
    check_val("arst_latency", first, DB - 1);
    for (int i = 0; i < 6; i++) step(1'b0, 4'h0);
    check_seq("arst_seq", 1, 32'h7);

    // Randomized traffic
    for (int s = 0; s < 80; s++) begin
      logic [3:0] c;
      int hold, rel, stall;
      c     = 4'($urandom_range(0, 15));
      hold  = $urandom_range(1, 8);
      rel   = $urandom_range(1, 6);
      stall = $urandom_range(0, 3);
      for (int i = 0; i < hold + rel; i++) begin
        out_ready = (stall == 0) ? 1'b0 : 1'($urandom_range(0, 3) != 0);
        clear_ovf = 1'($urandom_range(0, 9) == 0);
        if (i < hold) begin
          if ($urandom_range(0, 9) == 0) c = 4'($urandom_range(0, 15));
          step(($urandom_range(0, 11) != 0), c);
        end else begin
          step(($urandom_range(0, 7) == 0), c);
        end
      end
    end
    clear_ovf = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) step(1'b0, 4'h0);
    check_val("final_count", fifo_count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
